// File: rtl/mem_arb.sv
// mem_arb: round-robin arbiter sharing one single-cycle memory port between fetch and data requesters.
// Each access runs IDLE (grant) -> BUSY (memory cycle) -> DONE (ack pulse).
module mem_arb #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic          i_ack,
   output logic [DW-1:0] i_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_ack,
   output logic [DW-1:0] d_rdata,
   output logic [AW-1:0] m_addr,
   output logic          m_we,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t        state_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q, i_rdata_q, d_rdata_q;
   logic          we_q, win_d, win_q, last_q, i_ack_q, d_ack_q;
   // last_q is 1 when data won the previous grant; reset to 0 so data wins first
   assign win_d   = d_req & (~i_req | ~last_q);
   assign m_addr  = addr_q;
   assign m_wdata = wdata_q;
   // a reset arriving during BUSY must suppress the write on that same edge
   assign m_we    = (state_q == BUSY) & we_q & ~reset;
   assign i_ack   = i_ack_q;
   assign d_ack   = d_ack_q;
   assign i_rdata = i_rdata_q;
   assign d_rdata = d_rdata_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         win_q     <= 1'b0;
         last_q    <= 1'b0;
         i_ack_q   <= 1'b0;
         d_ack_q   <= 1'b0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         i_ack_q <= 1'b0;
         d_ack_q <= 1'b0;
         case (state_q)
            IDLE: if (i_req | d_req) begin
               addr_q  <= win_d ? d_addr : i_addr;
               wdata_q <= win_d ? d_wdata : wdata_q;
               we_q    <= win_d & d_we;
               win_q   <= win_d;
               last_q  <= win_d;
               state_q <= BUSY;
            end
            BUSY: begin
               if (win_q) begin
                  d_rdata_q <= m_rdata;
                  d_ack_q   <= 1'b1;
               end else begin
                  i_rdata_q <= m_rdata;
                  i_ack_q   <= 1'b1;
               end
               state_q <= DONE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
